vga_timing_gen: RTL

Generates the 640x480 @ 60 Hz VGA raster for the board: free-running pixel counters `hCount`/`vCount`, active-low `hSync`/`vSync`, the `bright` display-area flag, and frame-rate ticks. It is the producing end of the `hCount`/`vCount`/`bright` interface consumed by the pixel/game controllers. It runs on the 100 MHz board clock, uses a divided pixel-enable, and drives the VGA connector syncs directly.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/tick_div.sv | 25 ++
 rtl/vga_timing_gen.sv | 91 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// 640x480 @ 60 Hz raster constants and the 12-bit colour palette shared
// between the timing generator and the pixel/game controllers.
package vga_pkg;

  localparam int VGA_PIX_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS_END   = 783;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS_END   = 514;

  localparam int CNT_W = 10;

  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;
  localparam logic [11:0] COLOR_RED    = 12'hF00;
  localparam logic [11:0] COLOR_GREEN  = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE   = 12'h00F;
  localparam logic [11:0] COLOR_YELLOW = 12'hFF0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator (master) to the pixel/game
// controllers (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             hSync;
  logic             vSync;
  logic             bright;
  logic             pix_en;
  logic             frame_tick;
  logic             move_tick;

  modport master (
    output hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_tick
  );

  modport slave (
    input hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_tick
  );

endinterface

// File: rtl/tick_div.sv
// Modulo-N counter advancing on en; tick is the combinational terminal-count
// pulse, so the caller acts on the same edge the counter wraps.
module tick_div #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate h/v counters with registered sync/bright
// decode, plus frame and motion ticks for the game logic.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV     = VGA_PIX_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS_END   = VGA_H_VIS_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS_END   = VGA_V_VIS_END,
  parameter int MOVE_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  logic             advance;
  logic             move_tick;
  logic [CNT_W-1:0] h_reg, h_next;
  logic [CNT_W-1:0] v_reg, v_next;
  logic             hsync_reg, vsync_reg, bright_reg;
  logic             pix_en_reg, frame_tick_reg;
  logic             h_vis_next, v_vis_next;

  tick_div #(.N(PIX_DIV)) u_pix_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (advance)
  );

  // frame_cnt lives here; move_tick shares the clk of the frame_tick it counts
  tick_div #(.N(MOVE_FRAMES), .W(8)) u_move_div (
    .clk  (clk),
    .rst  (rst),
    .en   (frame_tick_reg),
    .tick (move_tick)
  );

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (advance) begin
      if (h_reg == CNT_W'(H_TOTAL - 1)) begin
        h_next = '0;
        v_next = (v_reg == CNT_W'(V_TOTAL - 1)) ? '0 : v_reg + CNT_W'(1);
      end else begin
        h_next = h_reg + CNT_W'(1);
      end
    end
  end

  assign h_vis_next = (h_next >= CNT_W'(H_VIS_START)) && (h_next <= CNT_W'(H_VIS_END));
  assign v_vis_next = (v_next >= CNT_W'(V_VIS_START)) && (v_next <= CNT_W'(V_VIS_END));

  // Decode from the next counter values so syncs/bright move with the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg          <= '0;
      v_reg          <= '0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      bright_reg     <= 1'b0;
      pix_en_reg     <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      h_reg          <= h_next;
      v_reg          <= v_next;
      hsync_reg      <= (h_next >= CNT_W'(H_SYNC));
      vsync_reg      <= (v_next >= CNT_W'(V_SYNC));
      bright_reg     <= h_vis_next && v_vis_next;
      pix_en_reg     <= advance;
      frame_tick_reg <= advance && (h_next == '0) && (v_next == CNT_W'(V_VIS_END + 1));
    end
  end

  assign vga.hCount     = h_reg;
  assign vga.vCount     = v_reg;
  assign vga.hSync      = hsync_reg;
  assign vga.vSync      = vsync_reg;
  assign vga.bright     = bright_reg;
  assign vga.pix_en     = pix_en_reg;
  assign vga.frame_tick = frame_tick_reg;
  assign vga.move_tick  = move_tick;

endmodule
